// File: rtl/lane_rotator.sv
// Rotates one lane by a rho-table or external offset, at most STEP bits per cycle.
// Handshake: accept in IDLE, result held in DONE until out_ready.
module lane_rotator #(
    parameter int W    = 64,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] lane,
    input  logic [4:0]   l_n,
    input  logic         ext_en,
    input  logic [5:0]   ext_off,
    input  logic         dir,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] rotated,
    output logic         err,
    output logic         busy
);

    localparam int LW = $clog2(W);
    localparam logic [LW:0] STEP_V = (LW+1)'(STEP);

    typedef enum logic [1:0] {IDLE, LOAD, ROTATE, DONE} state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  lane_reg;
    logic          dir_reg;
    logic [4:0]    ln_reg;
    logic          ext_en_reg;
    logic [5:0]    ext_off_reg;
    logic [LW:0]   rem_reg;
    logic          err_reg;

    logic [5:0]    tbl_entry;
    logic [LW:0]   off_sel;
    logic          lookup_err;
    logic [LW:0]   amt;
    logic [W-1:0]  lane_step;

    function automatic logic [5:0] rho_entry(input logic [4:0] idx);
        case (idx)
            5'd0:  rho_entry = 6'd0;
            5'd1:  rho_entry = 6'd1;
            5'd2:  rho_entry = 6'd62;
            5'd3:  rho_entry = 6'd28;
            5'd4:  rho_entry = 6'd27;
            5'd5:  rho_entry = 6'd36;
            5'd6:  rho_entry = 6'd44;
            5'd7:  rho_entry = 6'd6;
            5'd8:  rho_entry = 6'd55;
            5'd9:  rho_entry = 6'd20;
            5'd10: rho_entry = 6'd3;
            5'd11: rho_entry = 6'd10;
            5'd12: rho_entry = 6'd43;
            5'd13: rho_entry = 6'd25;
            5'd14: rho_entry = 6'd39;
            5'd15: rho_entry = 6'd41;
            5'd16: rho_entry = 6'd45;
            5'd17: rho_entry = 6'd15;
            5'd18: rho_entry = 6'd21;
            5'd19: rho_entry = 6'd8;
            5'd20: rho_entry = 6'd18;
            5'd21: rho_entry = 6'd2;
            5'd22: rho_entry = 6'd61;
            5'd23: rho_entry = 6'd56;
            5'd24: rho_entry = 6'd14;
            default: rho_entry = 6'd0;
        endcase
    endfunction

    // Doubling the word turns a rotate into a plain shift plus a slice.
    function automatic logic [W-1:0] rot_left(input logic [W-1:0] x, input logic [LW-1:0] s);
        logic [2*W-1:0] t;
        t = {x, x} << s;
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rot_right(input logic [W-1:0] x, input logic [LW-1:0] s);
        logic [2*W-1:0] t;
        t = {x, x} >> s;
        return t[W-1:0];
    endfunction

    always_comb begin
        tbl_entry  = rho_entry(ln_reg);
        off_sel    = '0;
        lookup_err = 1'b0;
        if (ext_en_reg) begin
            off_sel = {1'b0, ext_off_reg[LW-1:0]};
        end else if (ln_reg < 5'd25) begin
            off_sel = {1'b0, tbl_entry[LW-1:0]};
        end else begin
            lookup_err = 1'b1;
        end
    end

    // rem is always below W, so the step amount fits the LW-bit shifter.
    always_comb begin
        amt       = (rem_reg > STEP_V) ? STEP_V : rem_reg;
        lane_step = dir_reg ? rot_right(lane_reg, amt[LW-1:0])
                            : rot_left(lane_reg, amt[LW-1:0]);
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = LOAD;
            end
            LOAD: begin
                state_next = (off_sel != '0) ? ROTATE : DONE;
            end
            ROTATE: begin
                if (rem_reg == amt) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            lane_reg    <= '0;
            dir_reg     <= 1'b0;
            ln_reg      <= '0;
            ext_en_reg  <= 1'b0;
            ext_off_reg <= '0;
            rem_reg     <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        lane_reg    <= lane;
                        dir_reg     <= dir;
                        ln_reg      <= l_n;
                        ext_en_reg  <= ext_en;
                        ext_off_reg <= ext_off;
                    end
                end
                LOAD: begin
                    rem_reg <= off_sel;
                    err_reg <= lookup_err;
                end
                ROTATE: begin
                    lane_reg <= lane_step;
                    rem_reg  <= rem_reg - amt;
                end
                default: ;
            endcase
        end
    end

    assign rotated = lane_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_lane_rotator.sv
// Drives five lane_rotator configurations in parallel from one stimulus stream
// and checks each against a bit-permutation reference model.
module tb_lane_rotator;

    localparam int ND = 5;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] lane;
    logic [4:0]  l_n;
    logic        ext_en;
    logic [5:0]  ext_off;
    logic        dir;
    logic        in_valid;
    logic        out_ready;

    logic [ND-1:0] in_ready_v, out_valid_v, err_v, busy_v;
    logic [63:0]   rot0, rot1, rot2;
    logic [7:0]    rot3;
    logic [31:0]   rot4;
    logic [63:0]   rot_a [ND];

    int w_of    [ND] = '{64, 64, 64, 8, 32};
    int step_of [ND] = '{1, 8, 4, 1, 32};
    int rho     [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                         41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_txn = 0;
    int          obs_lat [ND];
    logic [63:0] obs_rot [ND];
    logic        obs_err [ND];

    always #5 clk = ~clk;

    always_comb begin
        rot_a[0] = rot0;
        rot_a[1] = rot1;
        rot_a[2] = rot2;
        rot_a[3] = {56'b0, rot3};
        rot_a[4] = {32'b0, rot4};
    end

    lane_rotator #(.W(64), .STEP(1)) dut0 (
        .clk(clk), .rst(rst), .lane(lane), .l_n(l_n), .ext_en(ext_en), .ext_off(ext_off),
        .dir(dir), .in_valid(in_valid), .in_ready(in_ready_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .rotated(rot0), .err(err_v[0]), .busy(busy_v[0]));
    lane_rotator #(.W(64), .STEP(8)) dut1 (
        .clk(clk), .rst(rst), .lane(lane), .l_n(l_n), .ext_en(ext_en), .ext_off(ext_off),
        .dir(dir), .in_valid(in_valid), .in_ready(in_ready_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .rotated(rot1), .err(err_v[1]), .busy(busy_v[1]));
    lane_rotator #(.W(64), .STEP(4)) dut2 (
        .clk(clk), .rst(rst), .lane(lane), .l_n(l_n), .ext_en(ext_en), .ext_off(ext_off),
        .dir(dir), .in_valid(in_valid), .in_ready(in_ready_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .rotated(rot2), .err(err_v[2]), .busy(busy_v[2]));
    lane_rotator #(.W(8), .STEP(1)) dut3 (
        .clk(clk), .rst(rst), .lane(lane[7:0]), .l_n(l_n), .ext_en(ext_en), .ext_off(ext_off),
        .dir(dir), .in_valid(in_valid), .in_ready(in_ready_v[3]), .out_valid(out_valid_v[3]),
        .out_ready(out_ready), .rotated(rot3), .err(err_v[3]), .busy(busy_v[3]));
    lane_rotator #(.W(32), .STEP(32)) dut4 (
        .clk(clk), .rst(rst), .lane(lane[31:0]), .l_n(l_n), .ext_en(ext_en), .ext_off(ext_off),
        .dir(dir), .in_valid(in_valid), .in_ready(in_ready_v[4]), .out_valid(out_valid_v[4]),
        .out_ready(out_ready), .rotated(rot4), .err(err_v[4]), .busy(busy_v[4]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Each input bit lands at its rotated position; nothing else is set.
    function automatic logic [63:0] model_rot(input logic [63:0] x, input int w, input int off,
                                              input logic d);
        logic [63:0] r;
        int j;
        r = '0;
        for (int i = 0; i < w; i++) begin
            j = d ? (i - off + w) % w : (i + off) % w;
            r[j] = x[i];
        end
        return r;
    endfunction

    function automatic int model_off(input int ln, input logic ee, input int eo, input int w);
        if (ee) return eo % w;
        if (ln < 25) return rho[ln] % w;
        return 0;
    endfunction

    task automatic run_txn(input logic [63:0] x, input logic [4:0] ln, input logic ee,
                           input logic [5:0] eo, input logic d, input int hold);
        int c;
        int off;
        logic [ND-1:0] seen;
        lane = x; l_n = ln; ext_en = ee; ext_off = eo; dir = d;
        in_valid = 1'b1; out_ready = 1'b0;
        check("in_ready_idle", 64'(in_ready_v), 64'({ND{1'b1}}));
        @(posedge clk); #1;
        // Inputs change right after the accept edge; only captured values may matter.
        lane = {$urandom, $urandom}; dir = ~d; ext_en = ~ee; ext_off = ~eo; l_n = ~ln;
        in_valid = 1'($urandom);
        check("no_valid_at_accept", 64'(out_valid_v), 64'(0));
        seen = '0;
        c = 0;
        for (int k = 0; k < ND; k++) obs_lat[k] = -1;
        while (seen != {ND{1'b1}} && c < TIMEOUT) begin
            @(posedge clk); #1;
            c++;
            check("ready_busy_in_flight", 64'({in_ready_v, busy_v}), 64'({{ND{1'b0}}, {ND{1'b1}}}));
            for (int k = 0; k < ND; k++) begin
                if (!seen[k] && out_valid_v[k]) begin
                    seen[k]    = 1'b1;
                    obs_lat[k] = c;
                    obs_rot[k] = rot_a[k];
                    obs_err[k] = err_v[k];
                end
            end
            in_valid = 1'($urandom);
        end
        check("valid_within_bound", 64'(seen), 64'({ND{1'b1}}));
        for (int k = 0; k < ND; k++) begin
            off = model_off(int'(ln), ee, int'(eo), w_of[k]);
            check($sformatf("latency_dut%0d", k), 64'(obs_lat[k]),
                  64'(1 + (off + step_of[k] - 1) / step_of[k]));
            check($sformatf("rotated_dut%0d", k), obs_rot[k], model_rot(x, w_of[k], off, d));
            check($sformatf("err_dut%0d", k), 64'(obs_err[k]), 64'(!ee && ln >= 5'd25));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid_ready", 64'({out_valid_v, in_ready_v}), 64'({{ND{1'b1}}, {ND{1'b0}}}));
            for (int k = 0; k < ND; k++) begin
                check($sformatf("hold_rot_dut%0d", k), rot_a[k], obs_rot[k]);
                check($sformatf("hold_err_dut%0d", k), 64'(err_v[k]), 64'(obs_err[k]));
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("released_to_idle", 64'({out_valid_v, in_ready_v, busy_v}),
              64'({{ND{1'b0}}, {ND{1'b1}}, {ND{1'b0}}}));
        n_txn++;
        $display("txn %0d: lane=%h l_n=%0d ext_en=%0d ext_off=%0d dir=%0d rot0=%h lat0=%0d",
                 n_txn, x, ln, ee, eo, d, obs_rot[0], obs_lat[0]);
    endtask

    typedef struct {
        logic [63:0] x;
        logic [4:0]  ln;
        logic        ee;
        logic [5:0]  eo;
        logic        d;
        int          dut;
        logic [63:0] exp_rot;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];
    int   bad_cycles;

    initial begin
        vecs[0] = '{64'h1, 5'd1, 1'b0, 6'd0, 1'b0, 0, 64'h2, 2, 1'b0};
        vecs[1] = '{64'h1, 5'd2, 1'b0, 6'd0, 1'b0, 0, 64'h4000000000000000, 63, 1'b0};
        vecs[2] = '{64'h1, 5'd2, 1'b0, 6'd0, 1'b0, 1, 64'h4000000000000000, 9, 1'b0};
        vecs[3] = '{64'h81, 5'd2, 1'b0, 6'd0, 1'b0, 3, 64'h60, 7, 1'b0};
        vecs[4] = '{64'h0123456789ABCDEF, 5'd0, 1'b1, 6'd4, 1'b1, 2, 64'hF0123456789ABCDE, 2, 1'b0};
        vecs[5] = '{64'hA5, 5'd0, 1'b0, 6'd0, 1'b0, 3, 64'hA5, 1, 1'b0};
        vecs[6] = '{64'hA5, 5'd25, 1'b0, 6'd0, 1'b0, 3, 64'hA5, 1, 1'b1};

        rst = 1'b0; lane = '0; l_n = '0; ext_en = 1'b0; ext_off = '0; dir = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({in_ready_v, out_valid_v, busy_v, err_v}),
              64'({{ND{1'b1}}, {ND{1'b0}}, {ND{1'b0}}, {ND{1'b0}}}));
        check("reset_lane0", rot_a[0], 64'h0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].x, vecs[i].ln, vecs[i].ee, vecs[i].eo, vecs[i].d, 0);
            check($sformatf("vec%0d_rot", i), obs_rot[vecs[i].dut], vecs[i].exp_rot);
            check($sformatf("vec%0d_lat", i), 64'(obs_lat[vecs[i].dut]), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_err", i), 64'(obs_err[vecs[i].dut]), 64'(vecs[i].exp_err));
        end

        // ext_en overrides an out-of-range index and never flags err.
        run_txn(64'h1234, 5'd25, 1'b1, 6'd0, 1'b0, 0);
        check("ext_ln25_err", 64'(obs_err[0]), 64'(0));
        check("ext_ln25_rot", obs_rot[0], 64'h1234);

        // Consumer stalls for five cycles.
        run_txn(64'hDEADBEEFCAFEF00D, 5'd7, 1'b0, 6'd0, 1'b1, 5);

        // Reset in the middle of a long rotation discards the request.
        lane = 64'h1; l_n = 5'd2; ext_en = 1'b0; dir = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_rotate_busy", 64'(busy_v), 64'({ND{1'b1}}));
        rst = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_state", 64'({out_valid_v, in_ready_v, busy_v, err_v}),
              64'({{ND{1'b0}}, {ND{1'b1}}, {ND{1'b0}}, {ND{1'b0}}}));
        for (int k = 0; k < ND; k++) check($sformatf("rst_mid_lane_dut%0d", k), rot_a[k], 64'h0);
        rst = 1'b1; in_valid = 1'b0;
        bad_cycles = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid_v != '0 || in_ready_v != {ND{1'b1}}) bad_cycles++;
        end
        check("discarded_no_output", 64'(bad_cycles), 64'(0));

        for (int t = 0; t < 150; t++) begin
            run_txn({$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) == 0),
                    6'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lane_rotator.md
LANE_ROTATOR -- requirements
Module: lane_rotator

Interface
REQ-001 Parameter W, default 64: lane width in bits; SHALL be one of 8, 16, 32, 64.
REQ-002 Parameter STEP, default 1: maximum rotation distance per cycle; SHALL be a power of two with 1 <= STEP <= W.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 lane  in  W  input lane, sampled on the accept edge.
REQ-006 l_n  in  5  lane index x+5y; selects the rho offset from the internal table.
REQ-007 ext_en  in  1  1 = use ext_off instead of the table entry; sampled on the accept edge.
REQ-008 ext_off  in  6  external rotation offset.
REQ-009 dir  in  1  0 = rotate left, 1 = rotate right; sampled on the accept edge.
REQ-010 in_valid  in  1  request valid.
REQ-011 in_ready  out  1  block can accept a request.
REQ-012 out_valid  out  1  rotated result valid.
REQ-013 out_ready  in  1  consumer takes the result.
REQ-014 rotated  out  W  result lane.
REQ-015 err  out  1  l_n >= 25 on a table lookup; valid while out_valid = 1.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 Rho table, indexed by l_n 0..24: 0,1,62,28,27, 36,44,6,55,20, 3,10,43,25,39, 41,45,15,21,8, 18,2,61,56,14.
REQ-018 Effective offset off:
- table entry mod W, or ext_off mod W when ext_en = 1;
- mod W uses the low log2(W) bits.
REQ-019 l_n >= 25 with ext_en = 0: off = 0, err latched to 1; ext_en = 1 never sets err.
REQ-020 Result: dir = 0 gives rotl(lane, off); dir = 1 gives rotr(lane, off); no bits are lost or inserted.
REQ-021 FSM states: IDLE, LOAD, ROTATE, DONE.
REQ-022 IDLE:
- in_ready = 1;
- in_valid = 1 accepts the request, captures lane, dir, l_n, ext_en and ext_off, and moves to LOAD.
REQ-023 LOAD: offset resolved into remaining counter rem; next state ROTATE if rem != 0, else DONE.
REQ-024 ROTATE: each cycle rotates the register by min(STEP, rem) in direction dir and subtracts that amount from rem; moves to DONE when rem reaches 0.
REQ-025 Latency: out_valid rises exactly 1 + ceil(off/STEP) cycles after the accept edge.
REQ-026 DONE:
- out_valid = 1; rotated and err held stable;
- out_ready = 1 returns to IDLE on that edge;
- out_ready = 0 holds DONE indefinitely.
REQ-027 in_ready = 0 outside IDLE; in_valid outside IDLE is ignored and not queued.
REQ-028 A new request is accepted no earlier than the cycle after the DONE to IDLE transition; there is no back-to-back overlap.
REQ-029 rotated always drives the internal lane register, including while not valid; it is defined only when out_valid = 1.
REQ-030 rem is log2(W)+1 bits wide and never underflows.

Reset
REQ-031 rst = 0 at a rising edge forces the following, regardless of state (including mid-ROTATE or DONE):
- state IDLE;
- lane register, rem and err = 0;
- out_valid = 0, busy = 0, in_ready = 1 from the next cycle.
REQ-032 A request in flight at reset is discarded with no output.
REQ-033 in_valid is ignored during any cycle with rst = 0.

Verification
REQ-034 W=64, STEP=1: lane 0x0000000000000001, l_n=1, dir=0 -> rotated 0x0000000000000002, out_valid 2 cycles after accept, err=0.
REQ-035 W=64, STEP=1: lane 0x1, l_n=2 (off 62), dir=0 -> 0x4000000000000000 after 63 cycles; same with STEP=8 -> same value after 9 cycles.
REQ-036 W=8, STEP=1: lane 0x81, l_n=2 (off 62 mod 8 = 6), dir=0 -> 0x60 after 7 cycles.
REQ-037 W=64, STEP=4: ext_en=1, ext_off=4, dir=1, lane 0x0123456789ABCDEF -> 0xF0123456789ABCDE after 2 cycles.
REQ-038 Boundary cases, each with a concrete stimulus and required response:
- l_n=0 or l_n=25 with lane 0xA5 (W=8) -> rotated 0xA5 after 1 cycle; err=0 for l_n=0, err=1 for l_n=25.
- out_ready held 0 for 5 cycles -> out_valid and rotated held unchanged and in_ready stays 0 throughout.
- rst=0 mid-ROTATE -> IDLE next cycle with out_valid=0.
